// File: rtl/tile_arb_pkg.sv
// Shared owner encoding, requester IDs and counter sizing for the tile RAM arbiter.
package tile_arb_pkg;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_EV   = 2'd2
    } owner_e;

    localparam logic REQ_ID_CPU = 1'b0;
    localparam logic REQ_ID_EV  = 1'b1;

    // One width covers both the burst counter and the wait counters.
    function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
        int unsigned m;
        m = (a > b) ? a : b;
        return unsigned'($clog2(m + 1));
    endfunction

endpackage

// File: rtl/arb_starve_ctr.sv
// Saturating wait counter: counts cycles a request goes ungranted, clears on grant.
module arb_starve_ctr #(
    parameter int unsigned LIMIT = 15,
    parameter int unsigned CNT_W = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic req,
    input  logic gnt,
    output logic starved
);

    localparam logic [CNT_W-1:0] Limit = CNT_W'(LIMIT);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (gnt) begin
            cnt_q <= '0;
        end else if (req && (cnt_q != Limit)) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign starved = (cnt_q == Limit);

endmodule

// File: rtl/tile_ram_arbiter.sv
// Shares one synchronous RAM port: video always wins, CPU and evaluator alternate in bursts.
// Define TILE_ARB_STARVE_EN to add per-port starvation counters that force a grant.
module tile_ram_arbiter #(
    parameter int unsigned ADDR_W       = 10,
    parameter int unsigned DATA_W       = 8,
    parameter int unsigned MAX_BURST    = 4,
    parameter int unsigned STARVE_LIMIT = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic              vid_rvalid,
    output logic [DATA_W-1:0] vid_rdata,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              ev_req,
    input  logic              ev_we,
    input  logic [ADDR_W-1:0] ev_addr,
    input  logic [DATA_W-1:0] ev_wdata,
    output logic              ev_gnt,
    output logic              ev_rvalid,
    output logic [DATA_W-1:0] ev_rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              starve_flag
);

    import tile_arb_pkg::*;

    localparam int unsigned     CntW     = cnt_width(MAX_BURST, STARVE_LIMIT);
    localparam logic [CntW-1:0] BurstMax = CntW'(MAX_BURST);

    owner_e            owner_q;
    logic              last_served_q;
    logic [CntW-1:0]   burst_q;
    logic [ADDR_W-1:0] ram_addr_q;
    logic              vid_rvalid_q;
    logic              cpu_rvalid_q;
    logic              ev_rvalid_q;

    logic vid_hit;
    logic cpu_pick;
    logic ev_pick;
    logic forced;
    logic burst_full;

    assign vid_hit    = vid_req & ~reset;
    assign burst_full = (burst_q == BurstMax);

`ifdef TILE_ARB_STARVE_EN
    logic cpu_starved;
    logic ev_starved;

    arb_starve_ctr #(
        .LIMIT (STARVE_LIMIT),
        .CNT_W (CntW)
    ) u_cpu_starve (
        .clk     (clk),
        .reset   (reset),
        .req     (cpu_req),
        .gnt     (cpu_pick),
        .starved (cpu_starved)
    );

    arb_starve_ctr #(
        .LIMIT (STARVE_LIMIT),
        .CNT_W (CntW)
    ) u_ev_starve (
        .clk     (clk),
        .reset   (reset),
        .req     (ev_req),
        .gnt     (ev_pick),
        .starved (ev_starved)
    );
`endif

    always_comb begin
        cpu_pick = 1'b0;
        ev_pick  = 1'b0;
        forced   = 1'b0;
        if (!reset && !vid_req) begin
            if (owner_q == OWN_CPU && cpu_req) begin
                ev_pick  = burst_full && ev_req;
                cpu_pick = !ev_pick;
            end else if (owner_q == OWN_EV && ev_req) begin
                cpu_pick = burst_full && cpu_req;
                ev_pick  = !cpu_pick;
            end else if (cpu_req && ev_req) begin
                cpu_pick = (last_served_q == REQ_ID_EV);
                ev_pick  = !cpu_pick;
            end else begin
                cpu_pick = cpu_req;
                ev_pick  = ev_req;
            end
`ifdef TILE_ARB_STARVE_EN
            // A starved port overrides whatever the burst logic chose; CPU wins a double starve.
            if (cpu_req && cpu_starved && !cpu_pick) begin
                cpu_pick = 1'b1;
                ev_pick  = 1'b0;
                forced   = 1'b1;
            end else if (ev_req && ev_starved && !ev_pick && !(cpu_req && cpu_starved)) begin
                cpu_pick = 1'b0;
                ev_pick  = 1'b1;
                forced   = 1'b1;
            end
`endif
        end
    end

    always_comb begin
        ram_addr  = ram_addr_q;
        ram_we    = 1'b0;
        ram_wdata = cpu_wdata;
        if (vid_hit) begin
            ram_addr = vid_addr;
        end else if (cpu_pick) begin
            ram_addr = cpu_addr;
            ram_we   = cpu_we;
        end else if (ev_pick) begin
            ram_addr  = ev_addr;
            ram_we    = ev_we;
            ram_wdata = ev_wdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            owner_q       <= OWN_NONE;
            last_served_q <= REQ_ID_EV;
            burst_q       <= '0;
            ram_addr_q    <= '0;
            vid_rvalid_q  <= 1'b0;
            cpu_rvalid_q  <= 1'b0;
            ev_rvalid_q   <= 1'b0;
        end else begin
            vid_rvalid_q <= vid_hit;
            cpu_rvalid_q <= cpu_pick & ~cpu_we;
            ev_rvalid_q  <= ev_pick & ~ev_we;
            ram_addr_q   <= ram_addr;
            // Video cycles pick nobody, so the burst count only moves on real grants.
            if (cpu_pick) begin
                owner_q       <= OWN_CPU;
                last_served_q <= REQ_ID_CPU;
                burst_q       <= (owner_q == OWN_CPU && !burst_full) ? burst_q + CntW'(1)
                                                                     : CntW'(1);
            end else if (ev_pick) begin
                owner_q       <= OWN_EV;
                last_served_q <= REQ_ID_EV;
                burst_q       <= (owner_q == OWN_EV && !burst_full) ? burst_q + CntW'(1)
                                                                    : CntW'(1);
            end else if ((owner_q == OWN_CPU && !cpu_req) || (owner_q == OWN_EV && !ev_req)) begin
                owner_q <= OWN_NONE;
                burst_q <= '0;
            end
        end
    end

    assign cpu_gnt     = cpu_pick;
    assign ev_gnt      = ev_pick;
    assign starve_flag = forced;
    assign vid_rvalid  = vid_rvalid_q;
    assign cpu_rvalid  = cpu_rvalid_q;
    assign ev_rvalid   = ev_rvalid_q;
    assign vid_rdata   = ram_rdata;
    assign cpu_rdata   = ram_rdata;
    assign ev_rdata    = ram_rdata;

endmodule

// File: tb/tb_tile_ram_arbiter.sv
// Scoreboard bench for tile_ram_arbiter: grant schedules, read returns and reset behaviour.
module tb_tile_ram_arbiter;

    localparam int AW = 10;
    localparam int DW = 8;
`ifdef TILE_ARB_STARVE_EN
    localparam int MB = 8;
    localparam int SL = 3;
`else
    localparam int MB = 4;
    localparam int SL = 15;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          vid_req, vid_rvalid;
    logic [AW-1:0] vid_addr;
    logic [DW-1:0] vid_rdata;
    logic          cpu_req, cpu_we, cpu_gnt, cpu_rvalid;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata, cpu_rdata;
    logic          ev_req, ev_we, ev_gnt, ev_rvalid;
    logic [AW-1:0] ev_addr;
    logic [DW-1:0] ev_wdata, ev_rdata;
    logic [AW-1:0] ram_addr;
    logic          ram_we;
    logic [DW-1:0] ram_wdata, ram_rdata;
    logic          starve_flag;

    tile_ram_arbiter #(
        .ADDR_W       (AW),
        .DATA_W       (DW),
        .MAX_BURST    (MB),
        .STARVE_LIMIT (SL)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .vid_req     (vid_req),
        .vid_addr    (vid_addr),
        .vid_rvalid  (vid_rvalid),
        .vid_rdata   (vid_rdata),
        .cpu_req     (cpu_req),
        .cpu_we      (cpu_we),
        .cpu_addr    (cpu_addr),
        .cpu_wdata   (cpu_wdata),
        .cpu_gnt     (cpu_gnt),
        .cpu_rvalid  (cpu_rvalid),
        .cpu_rdata   (cpu_rdata),
        .ev_req      (ev_req),
        .ev_we       (ev_we),
        .ev_addr     (ev_addr),
        .ev_wdata    (ev_wdata),
        .ev_gnt      (ev_gnt),
        .ev_rvalid   (ev_rvalid),
        .ev_rdata    (ev_rdata),
        .ram_addr    (ram_addr),
        .ram_we      (ram_we),
        .ram_wdata   (ram_wdata),
        .ram_rdata   (ram_rdata),
        .starve_flag (starve_flag)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        int          due;
        logic [7:0]  data;
    } exp_t;

    exp_t       vid_q[$];
    exp_t       cpu_q[$];
    exp_t       ev_q[$];
    logic [7:0] mem[1024];
    logic [7:0] shadow[1024];
    logic [AW-1:0] last_addr;
    int         errors = 0;
    int         checks = 0;
    int         cyc = 0;
    logic       exp_v;
    exp_t       e;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // Single-port synchronous RAM the arbiter drives.
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (reset) begin
            check_eq("rst_vid_rvalid", {31'd0, vid_rvalid}, 0);
            check_eq("rst_cpu_rvalid", {31'd0, cpu_rvalid}, 0);
            check_eq("rst_ev_rvalid", {31'd0, ev_rvalid}, 0);
            check_eq("rst_gnt", {30'd0, cpu_gnt, ev_gnt}, 0);
            vid_q.delete();
            cpu_q.delete();
            ev_q.delete();
            last_addr = '0;
        end else begin
            exp_v = (vid_q.size() > 0) && (vid_q[0].due == cyc);
            check_eq("vid_rvalid", {31'd0, vid_rvalid}, {31'd0, exp_v});
            if (exp_v) begin
                check_eq("vid_rdata", {24'd0, vid_rdata}, {24'd0, vid_q[0].data});
                void'(vid_q.pop_front());
            end
            exp_v = (cpu_q.size() > 0) && (cpu_q[0].due == cyc);
            check_eq("cpu_rvalid", {31'd0, cpu_rvalid}, {31'd0, exp_v});
            if (exp_v) begin
                check_eq("cpu_rdata", {24'd0, cpu_rdata}, {24'd0, cpu_q[0].data});
                void'(cpu_q.pop_front());
            end
            exp_v = (ev_q.size() > 0) && (ev_q[0].due == cyc);
            check_eq("ev_rvalid", {31'd0, ev_rvalid}, {31'd0, exp_v});
            if (exp_v) begin
                check_eq("ev_rdata", {24'd0, ev_rdata}, {24'd0, ev_q[0].data});
                void'(ev_q.pop_front());
            end
            check_eq("gnt_onehot", {31'd0, cpu_gnt & ev_gnt}, 0);
            if (vid_req) begin
                check_eq("vid_ram_addr", {22'd0, ram_addr}, {22'd0, vid_addr});
                check_eq("vid_ram_we", {31'd0, ram_we}, 0);
                check_eq("vid_blocks_gnt", {30'd0, cpu_gnt, ev_gnt}, 0);
                e.due = cyc + 1;
                e.data = shadow[vid_addr];
                vid_q.push_back(e);
                last_addr = vid_addr;
            end else if (cpu_gnt) begin
                check_eq("cpu_ram_addr", {22'd0, ram_addr}, {22'd0, cpu_addr});
                check_eq("cpu_ram_we", {31'd0, ram_we}, {31'd0, cpu_we});
                if (cpu_we) begin
                    check_eq("cpu_ram_wdata", {24'd0, ram_wdata}, {24'd0, cpu_wdata});
                    shadow[cpu_addr] = cpu_wdata;
                end else begin
                    e.due = cyc + 1;
                    e.data = shadow[cpu_addr];
                    cpu_q.push_back(e);
                end
                last_addr = cpu_addr;
            end else if (ev_gnt) begin
                check_eq("ev_ram_addr", {22'd0, ram_addr}, {22'd0, ev_addr});
                check_eq("ev_ram_we", {31'd0, ram_we}, {31'd0, ev_we});
                if (ev_we) begin
                    check_eq("ev_ram_wdata", {24'd0, ram_wdata}, {24'd0, ev_wdata});
                    shadow[ev_addr] = ev_wdata;
                end else begin
                    e.due = cyc + 1;
                    e.data = shadow[ev_addr];
                    ev_q.push_back(e);
                end
                last_addr = ev_addr;
            end else begin
                check_eq("idle_ram_we", {31'd0, ram_we}, 0);
                check_eq("idle_ram_addr_hold", {22'd0, ram_addr}, {22'd0, last_addr});
            end
        end
    end

    task automatic tick(input string tag, input logic ec, input logic ee, input logic es);
        @(negedge clk);
        check_eq({tag, "_cpu_gnt"}, {31'd0, cpu_gnt}, {31'd0, ec});
        check_eq({tag, "_ev_gnt"}, {31'd0, ev_gnt}, {31'd0, ee});
        check_eq({tag, "_starve"}, {31'd0, starve_flag}, {31'd0, es});
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    logic pat_cpu[11];
    logic pat_ev[11];

    initial begin
        for (int i = 0; i < 1024; i++) begin
            mem[i] = 8'(i) ^ 8'h5A;
            shadow[i] = 8'(i) ^ 8'h5A;
        end
        vid_req = 0; vid_addr = '0;
        cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
        ev_req = 0; ev_we = 0; ev_addr = '0; ev_wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_ram_addr", {22'd0, ram_addr}, 0);
        check_eq("rst_ram_we", {31'd0, ram_we}, 0);
        check_eq("rst_starve", {31'd0, starve_flag}, 0);
        check_eq("rst_cpu_gnt", {31'd0, cpu_gnt}, 0);
        reset = 1'b0;

        // Video wins the collision, CPU is served the next cycle.
        vid_req = 1; vid_addr = 10'h045;
        cpu_req = 1; cpu_we = 0; cpu_addr = 10'h010;
        tick("vid_pri", 0, 0, 0);
        vid_req = 0;
        tick("cpu_after_vid", 1, 0, 0);
        cpu_req = 0;
        tick("idle_a", 0, 0, 0);
        tick("idle_b", 0, 0, 0);

        pulse_reset();
`ifdef TILE_ARB_STARVE_EN
        cpu_req = 1; cpu_addr = 10'h100;
        ev_req = 1; ev_addr = 10'h200;
        tick("st0", 1, 0, 0);
        tick("st1", 1, 0, 0);
        tick("st2", 1, 0, 0);
        tick("st_force", 0, 1, 1);
        ev_req = 0;
        tick("st_after", 1, 0, 0);
        cpu_req = 0;
        tick("st_idle", 0, 0, 0);
`else
        // Ten cycles of CPU against a continuous evaluator: 4 / 4 / 2, then EV alone.
        pat_cpu = '{1, 1, 1, 1, 0, 0, 0, 0, 1, 1, 0};
        pat_ev  = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 1};
        cpu_addr = 10'h100; ev_addr = 10'h200;
        ev_req = 1;
        for (int i = 0; i < 11; i++) begin
            cpu_req = (i < 10);
            tick($sformatf("rr%0d", i), pat_cpu[i], pat_ev[i], 0);
            if (pat_cpu[i]) cpu_addr = cpu_addr + 1;
            if (pat_ev[i]) ev_addr = ev_addr + 1;
        end
        ev_req = 0;
        tick("rr_idle", 0, 0, 0);

        // A video cycle inside a burst must not consume burst budget.
        cpu_req = 1; ev_req = 1; cpu_addr = 10'h120; ev_addr = 10'h220;
        tick("vb0", 1, 0, 0);
        tick("vb1", 1, 0, 0);
        vid_req = 1; vid_addr = 10'h300;
        tick("vb_vid", 0, 0, 0);
        vid_req = 0;
        tick("vb3", 1, 0, 0);
        tick("vb4", 1, 0, 0);
        tick("vb_ev", 0, 1, 0);
        cpu_req = 0; ev_req = 0;
        tick("vb_idle", 0, 0, 0);
`endif

        // A lone owner keeps getting grants past the burst limit.
        cpu_req = 1; cpu_addr = 10'h080;
        for (int i = 0; i < MB + 2; i++) begin
            tick($sformatf("solo%0d", i), 1, 0, 0);
            cpu_addr = cpu_addr + 1;
        end
        cpu_req = 0;
        tick("solo_idle", 0, 0, 0);

        // Evaluator write then read of the last cell.
        ev_req = 1; ev_we = 1; ev_addr = 10'h3FF; ev_wdata = 8'hA5;
        tick("ev_wr", 0, 1, 0);
        ev_we = 0;
        tick("ev_rd", 0, 1, 0);
        ev_req = 0;
        @(negedge clk);
        check_eq("ev_rvalid_a5", {31'd0, ev_rvalid}, 1);
        check_eq("ev_rdata_a5", {24'd0, ev_rdata}, 32'hA5);
        @(posedge clk);
        #1;
        tick("ev_idle", 0, 0, 0);

        // Reset lands right after a CPU read grant: the return must be dropped.
        cpu_req = 1; cpu_we = 0; cpu_addr = 10'h0AA;
        @(negedge clk);
        check_eq("pre_rst_cpu_gnt", {31'd0, cpu_gnt}, 1);
        #2;
        reset = 1'b1;
        @(negedge clk);
        check_eq("mid_rst_cpu_rvalid", {31'd0, cpu_rvalid}, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        cpu_req = 1; ev_req = 1; ev_addr = 10'h0BB;
        tick("post_rst_tie", 1, 0, 0);
        cpu_req = 0; ev_req = 0;
        tick("end_a", 0, 0, 0);
        tick("end_b", 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not reach its summary");
        $fatal(1);
    end

endmodule

// File: doc/tile_ram_arbiter.md
TILE_RAM_ARBITER -- requirements
Module: tile_ram_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, RAM address width (32x32 tile array).
REQ-002 SHALL have parameter DATA_W, default 8, RAM data width.
REQ-003 SHALL have parameter MAX_BURST, default 4, consecutive grants an owner may take while the other port waits.
REQ-004 SHALL have parameter STARVE_LIMIT, default 15, wait cycles before forced grant.
REQ-005 SHALL use one clock; reset is asynchronous and active-high.
REQ-006 SHALL have port clk  in  1  system clock.
REQ-007 SHALL have port reset  in  1  async active-high reset.
REQ-008 SHALL have ports vid_req in 1, vid_addr in ADDR_W: video scan fetch, never stalled.
REQ-009 SHALL have ports vid_rvalid out 1, vid_rdata out DATA_W: video read return.
REQ-010 SHALL have ports cpu_req in 1, cpu_we in 1, cpu_addr in ADDR_W, cpu_wdata in DATA_W, cpu_gnt out 1, cpu_rvalid out 1, cpu_rdata out DATA_W.
REQ-011 SHALL have ports ev_req, ev_we, ev_addr, ev_wdata, ev_gnt, ev_rvalid, ev_rdata, same widths, for the map cell evaluator.
REQ-012 SHALL have ports ram_addr out ADDR_W, ram_we out 1, ram_wdata out DATA_W, ram_rdata in DATA_W: single-port synchronous RAM.
REQ-013 SHALL have port starve_flag  out  1  one-cycle pulse on a forced grant.

Function
REQ-014 SHALL drive the RAM combinationally from the winner of the current cycle; RAM read latency 1 cycle.
REQ-015 SHALL give vid_req absolute priority; in a vid_req cycle cpu_gnt=ev_gnt=0 and ram_we=0.
REQ-016 SHALL assert x_rvalid exactly one cycle after a read grant, with x_rdata = ram_rdata; writes produce no rvalid.
REQ-017 SHALL hold requests until gnt; gnt high one cycle = access issued that cycle; req dropped before gnt issues nothing.
REQ-018 SHALL implement states IDLE, OWN_CPU, OWN_EV: IDLE->owner on first non-video grant; owner->IDLE when its req falls.
REQ-019 SHALL, in IDLE with both requesting, grant the port not last served (round-robin).
REQ-020 SHALL let the owner keep consecutive grants while req is high until burst count reaches MAX_BURST, then switch to the other port if it requests, else restart the count.
REQ-021 SHALL not advance the burst count in video-preempted cycles.
REQ-022 SHALL saturate the burst counter at MAX_BURST; no wrap.
REQ-023 SHALL keep ram_addr at its last value and ram_we=0 when nothing is granted.

Reset
REQ-024 SHALL on reset: state IDLE, last_served=EV (CPU wins first tie), all gnt/rvalid/ram_we/starve_flag 0, ram_addr 0, counters 0.
REQ-025 SHALL on reset mid-burst drop the pending rvalid and discard the burst.

Configuration
REQ-026 SHALL with TILE_ARB_STARVE_EN defined keep per-port saturating wait counters (reset on grant); at STARVE_LIMIT the waiting port wins the next non-video cycle overriding burst, starve_flag pulses.
REQ-027 SHALL without TILE_ARB_STARVE_EN omit the counters and tie starve_flag to 0.

Structure
REQ-028 SHALL place the owner enum (OWN_NONE/OWN_CPU/OWN_EV) and the requester-ID constants in shared package tile_arb_pkg.
REQ-029 SHALL implement wait counters as sub-module arb_starve_ctr, instantiated once per port.

Verification
REQ-030 SHALL cover: vid_req=1 addr 0x045, cpu_req read 0x010 same cycle -> video served, cpu_gnt next cycle, vid_rvalid at +1.
REQ-031 SHALL cover: cpu and ev both req from reset -> cpu_gnt first, ev_gnt after the burst.
REQ-032 SHALL cover: cpu holds req 10 cycles, ev req continuous -> cpu 4 grants, ev 4, cpu 2.
REQ-033 SHALL cover: ev write 0xA5 to 0x3FF, then ev read 0x3FF -> ev_rvalid with ev_rdata=0xA5.
REQ-034 SHALL cover: with TILE_ARB_STARVE_EN, STARVE_LIMIT=3, MAX_BURST=8, cpu continuous, ev waiting -> ev granted after 3 waits, starve_flag 1 cycle.
REQ-035 SHALL cover: reset asserted cycle after cpu read grant -> cpu_rvalid stays 0, state IDLE.
